// File: rtl/boot_mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// boot_mem_arbiter : shares the program/data memory between CU and bootloader
// Revision 1.0
// ---------------------------------------------------------------------------
module boot_mem_arbiter #(
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 8,
    parameter int IDLE_TIMEOUT = 255
) (
    input  logic              slowclk,
    input  logic              nReset,
    input  logic              boot_req,
    input  logic              boot_valid,
    input  logic [DATA_W-1:0] boot_data,
    output logic              boot_ready,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic              Bootload,
    output logic [ADDR_W:0]   boot_count,
    output logic              boot_done,
    output logic              boot_timeout,
    output logic              cpu_err
);

    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [ADDR_W:0]   FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   LAST_COUNT = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(IDLE_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        LOAD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t             state, state_nx;
    logic               req_q;
    logic               drain_cnt;
    logic [ADDR_W-1:0]  ptr;
    logic [ADDR_W:0]    count_r;
    logic [IDLE_W-1:0]  idle;
    logic               timeout_r;
    logic               err_r;

    logic               start;
    logic               beat;
    logic               last_beat;
    logic               idle_expire;
    logic               enter_load;
    logic               err_set;
    logic               timeout_set;

    assign start       = boot_req & ~req_q;
    assign boot_ready  = (state == LOAD) && (count_r < FULL_COUNT);
    assign beat        = boot_valid & boot_ready;
    assign last_beat   = beat && (count_r == LAST_COUNT);
    assign idle_expire = !beat && (idle == IDLE_LAST);
    assign enter_load  = (state == DRAIN) && drain_cnt;

    always_comb begin
        state_nx    = state;
        mem_addr    = cpu_addr;
        mem_wdata   = cpu_wdata;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        err_set     = 1'b0;
        timeout_set = 1'b0;
        case (state)
            RUN: begin
                // Simultaneous rd/wr resolves to a write
                mem_re  = cpu_rd & ~cpu_wr;
                mem_we  = cpu_wr;
                err_set = cpu_rd & cpu_wr;
                if (start) state_nx = DRAIN;
            end
            DRAIN: begin
                mem_re  = cpu_rd & ~cpu_wr;
                mem_we  = cpu_wr;
                err_set = cpu_rd & cpu_wr;
                if (drain_cnt) state_nx = LOAD;
            end
            LOAD: begin
                mem_addr  = ptr;
                mem_wdata = boot_data;
                mem_we    = beat;
                err_set   = cpu_rd | cpu_wr;
                if ((count_r == FULL_COUNT) || last_beat || !boot_req) begin
                    state_nx = RELEASE;
                end else if (idle_expire) begin
                    state_nx    = RELEASE;
                    timeout_set = 1'b1;
                end
            end
            RELEASE: begin
                err_set  = cpu_rd | cpu_wr;
                state_nx = RUN;
            end
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge slowclk or negedge nReset) begin
        if (!nReset) begin
            state     <= RUN;
            req_q     <= 1'b0;
            drain_cnt <= 1'b0;
            ptr       <= '0;
            count_r   <= '0;
            idle      <= '0;
            timeout_r <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state     <= state_nx;
            req_q     <= boot_req;
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            if (enter_load) begin
                ptr       <= '0;
                count_r   <= '0;
                idle      <= '0;
                timeout_r <= 1'b0;
                err_r     <= 1'b0;
            end else begin
                if (state == LOAD) begin
                    if (beat) begin
                        ptr     <= ptr + ADDR_W'(1);
                        count_r <= count_r + (ADDR_W+1)'(1);
                        idle    <= '0;
                    end else begin
                        idle    <= idle + IDLE_W'(1);
                    end
                end
                if (timeout_set) timeout_r <= 1'b1;
                if (err_set)     err_r     <= 1'b1;
            end
        end
    end

    assign Bootload     = (state != RUN);
    assign boot_done    = (state == RELEASE);
    assign boot_count   = count_r;
    assign boot_timeout = timeout_r;
    assign cpu_err      = err_r;

endmodule
`default_nettype wire
